// File: rtl/scan_ctrl_pkg.sv
// Shared types and helpers for the scan chain controller.
// Holds the pass state encoding and the counter width derivation.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } scan_state_t;

  // Wide enough to hold CHAIN_LEN itself, so saturating counts fit too.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_beat_counter.sv
// Beat counter shared by LOAD and UNLOAD: loadable, wraps to 0 after the
// beat at CHAIN_LEN-1, and flags that final beat with last.
module scan_beat_counter
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign last = (cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan pass sequencer: LOAD a pattern via SI, optional CAPTURE edge, UNLOAD via
// SO with masked compare; reports fail, error count and first failing beat.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic             clk,
  input  logic             global_resetn,
  input  logic             start,
  input  logic             capture_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_data,
  input  logic             in_mask,
  output logic             scan_mode,
  output logic             scan_en,
  output logic             chain_ce,
  output logic             chain_si,
  input  logic             chain_so,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_fail_idx
);

  // Host stream handshake: a beat transfers on any cycle where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.

  scan_state_t      state_d, state_q;
  logic             cap_d, cap_q;
  logic             fail_d, fail_q;
  logic [CNT_W-1:0] err_d, err_q;
  logic [CNT_W-1:0] idx_d, idx_q;
  logic             scan_mode_d, scan_mode_q;
  logic             scan_en_d, scan_en_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;

  logic             start_acc;
  logic             beat;
  logic             mismatch;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign start_acc = (state_q == S_IDLE) && start;
  assign beat      = in_ready && in_valid;
  assign mismatch  = (state_q == S_UNLOAD) && beat && !in_mask && (chain_so != in_data);

  scan_beat_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (global_resetn),
    .load     (start_acc),
    .load_val ('0),
    .inc      (beat),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_LOAD;
      S_LOAD:    if (beat && cnt_last) state_d = cap_q ? S_CAPTURE : S_UNLOAD;
      S_CAPTURE: state_d = S_UNLOAD;
      S_UNLOAD:  if (beat && cnt_last) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Combinational chain controls from the current state; registered status
  // outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    in_ready    = (state_q == S_LOAD) || (state_q == S_UNLOAD);
    chain_ce    = (in_ready && in_valid) || (state_q == S_CAPTURE);
    chain_si    = (state_q == S_LOAD) ? in_data : 1'b0;
    scan_mode_d = (state_d == S_LOAD) || (state_d == S_CAPTURE) || (state_d == S_UNLOAD);
    busy_d      = scan_mode_d;
    scan_en_d   = (state_d == S_LOAD) || (state_d == S_UNLOAD);
    done_d      = (state_d == S_DONE);
  end

  always_comb begin
    cap_d  = cap_q;
    fail_d = fail_q;
    err_d  = err_q;
    idx_d  = idx_q;
    if (start_acc) begin
      cap_d  = capture_en;
      fail_d = 1'b0;
      err_d  = '0;
      idx_d  = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      err_d  = (err_q == '1) ? err_q : err_q + CNT_W'(1);
      if (!fail_q) idx_d = cnt;
    end
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      cap_q       <= 1'b0;
      fail_q      <= 1'b0;
      err_q       <= '0;
      idx_q       <= '0;
      scan_mode_q <= 1'b0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      fail_q      <= fail_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      scan_mode_q <= scan_mode_d;
      scan_en_q   <= scan_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign scan_mode      = scan_mode_q;
  assign scan_en        = scan_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign err_count      = err_q;
  assign first_fail_idx = idx_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl with an 8-FF chain model; capture edges invert the
// chain. Directed passes push expected results; a monitor checks them on done.
module tb_scan_chain_ctrl;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int W  = 16 + 1 + CW + CW;

  logic          clk;
  logic          global_resetn;
  logic          start, capture_en;
  logic          in_valid, in_ready, in_data, in_mask;
  logic          scan_mode, scan_en, chain_ce, chain_si, chain_so;
  logic          busy, done, fail;
  logic [CW-1:0] err_count, first_fail_idx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int start_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [N-1:0] chain;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk            (clk),
    .global_resetn  (global_resetn),
    .start          (start),
    .capture_en     (capture_en),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mask        (in_mask),
    .scan_mode      (scan_mode),
    .scan_en        (scan_en),
    .chain_ce       (chain_ce),
    .chain_si       (chain_si),
    .chain_so       (chain_so),
    .busy           (busy),
    .done           (done),
    .fail           (fail),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx)
  );

  // Chain model: shift toward chain[0] (the SO end); capture inverts all FFs.
  always @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) chain <= '0;
    else if (chain_ce) begin
      if (scan_en) chain <= {chain_si, chain[N-1:1]};
      else         chain <= ~chain;
    end
  end
  assign chain_so = chain[0];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (global_resetn) begin
      if (in_ready) check("chain_ce_tracks_valid", int'(chain_ce), int'(in_valid));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency_edges", cyc - start_cyc, int'(mon_e[W-1 -: 16]));
          check("fail", int'(fail), int'(mon_e[2*CW]));
          check("err_count", int'(err_count), int'(mon_e[2*CW-1 -: CW]));
          check("first_fail_idx", int'(first_fail_idx), int'(mon_e[CW-1:0]));
          check("busy_in_done", int'(busy), 0);
          check("scan_mode_in_done", int'(scan_mode), 0);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_chain_ce"}, int'(chain_ce), 0);
    check({tag, "_chain_si"}, int'(chain_si), 0);
    check({tag, "_scan_mode"}, int'(scan_mode), 0);
    check({tag, "_scan_en"}, int'(scan_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
    check({tag, "_first_fail_idx"}, int'(first_fail_idx), 0);
  endtask

  // Entered and left at posedge+1; returns after the accepting edge.
  task automatic drive_beat(input logic d, input logic m, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    @(posedge clk); #1;
  endtask

  // Latency is counted in edges from start acceptance to the DONE cycle.
  task automatic run_pass(input logic cap, input logic [N-1:0] pat,
                          input logic [N-1:0] expv, input logic [N-1:0] mask,
                          input logic efail, input int eerr, input int eidx,
                          input int max_gap, input int abort_beat,
                          input logic start_in_done);
    int gaps[2*N];
    int gsum;
    int t;
    gsum = 0;
    for (int i = 0; i < 2*N; i++) begin
      gaps[i] = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      gsum += gaps[i];
    end
    if (abort_beat < 0)
      exp_q.push_back({16'(2*N + int'(cap) + gsum), efail, CW'(eerr), CW'(eidx)});
    start = 1'b1;
    capture_en = cap;
    @(posedge clk); #1;
    start = 1'b0;
    capture_en = 1'b0;
    start_cyc = cyc;
    for (int i = 0; i < N; i++) drive_beat(pat[i], 1'b0, gaps[i]);
    if (cap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int i = 0; i < N; i++) begin
      if (i == abort_beat) begin
        in_valid = 1'b1;
        in_data  = expv[i];
        in_mask  = 1'b0;
        #2 global_resetn = 1'b0;
        #1 check_all_zero("async_reset");
        in_valid = 1'b0;
        @(posedge clk); #2;
        global_resetn = 1'b1;
        @(posedge clk); #1;
        t = 0;
        while (t < 4) begin
          check("no_done_after_abort", int'(done), 0);
          @(posedge clk); #1;
          t++;
        end
        return;
      end
      drive_beat(expv[i], mask[i], gaps[N+i]);
    end
    in_valid = 1'b0;
    in_mask  = 1'b0;
    in_data  = 1'b0;
    if (start_in_done) begin
      start = 1'b1;
      capture_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      capture_en = 1'b0;
      check("start_ignored_in_done_busy", int'(busy), 0);
      check("start_ignored_in_done_ready", int'(in_ready), 0);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    global_resetn = 1'b0;
    start = 1'b0; capture_en = 1'b0;
    in_valid = 1'b0; in_data = 1'b0; in_mask = 1'b0;
    repeat (3) @(posedge clk);
    #1 global_resetn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset");

    // flush, capture, two mismatches, masked mismatch, then stalled variants
    run_pass(1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0, 0, 0, 0, -1, 1'b0);
    run_pass(1'b1, 8'hA5, 8'h5A, 8'h00, 1'b0, 0, 0, 0, -1, 1'b0);
    run_pass(1'b0, 8'hA5, 8'h81, 8'h00, 1'b1, 2, 2, 0, -1, 1'b1);
    check("fail_sticky_after_done", int'(fail), 1);
    check("err_sticky_after_done", int'(err_count), 2);
    run_pass(1'b0, 8'hA5, 8'h81, 8'h04, 1'b1, 1, 5, 0, -1, 1'b0);
    run_pass(1'b1, 8'hA5, 8'h5A, 8'h00, 1'b0, 0, 0, 5, -1, 1'b0);
    run_pass(1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0, 0, 0, 5, -1, 1'b0);
    run_pass(1'b0, 8'h3C, 8'hBC, 8'h00, 1'b1, 1, 7, 3, -1, 1'b0);

    // abort during UNLOAD beat 3 with mismatches already logged, then a clean pass
    run_pass(1'b0, 8'h96, 8'h91, 8'h00, 1'b1, 3, 0, 0, 3, 1'b0);
    run_pass(1'b1, 8'h96, 8'h69, 8'h00, 1'b0, 0, 0, 0, -1, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequences the scan path through a chain of CHAIN_LEN `ff_bypass` flip-flops in one CLB column. A single test pass has three phases: load a pattern through SI, optionally apply one functional capture cycle, then unload through SO and compare each bit against an expected stream. It drives the chain's global `scan_en`/`scan_mode` and the per-FF enable E, and reports pass/fail, error count and first failing position to the test host.

## Interface
Parameters:
- CHAIN_LEN, 64: number of scan FFs in the chain; legal range ≥1.
- CNT_W, $clog2(CHAIN_LEN+1): derived width of counters and indices; not overridden.

Ports:
- clk  in  1  chain clock; the same net that drives `ff_bypass_C`.
- global_resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a pass; ignored while busy.
- capture_en  in  1  sampled with start; 1 inserts the capture cycle, 0 gives a pure shift-through (flush) test.
- in_valid  in  1  host stream beat valid.
- in_ready  out  1  controller accepts a beat.
- in_data  in  1  pattern bit during LOAD, expected bit during UNLOAD.
- in_mask  in  1  UNLOAD only; 1 excludes this bit from the compare.
- scan_mode  out  1  high for the whole pass.
- scan_en  out  1  high in LOAD/UNLOAD, low in CAPTURE and IDLE.
- chain_ce  out  1  drives the FF enable E; each high cycle is one shift or capture edge.
- chain_si  out  1  serial data into the chain.
- chain_so  in  1  serial data out of the chain (registered FF output).
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of a pass.
- fail  out  1  at least one unmasked mismatch; held until the next accepted start.
- err_count  out  CNT_W  unmasked mismatches; saturates at all-ones.
- first_fail_idx  out  CNT_W  UNLOAD beat index of the first mismatch; meaningful only when fail=1.

## Operation
- States: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE: an accepted start clears fail, err_count and first_fail_idx, latches capture_en, zeroes the beat counter and moves to LOAD.
- LOAD:
  - in_ready=1 and chain_ce=in_valid.
  - chain_si=in_data.
  - Each accepted beat increments the counter.
  - On the beat with counter=CHAIN_LEN-1, go to CAPTURE if capture_en was latched high, else to UNLOAD. The counter resets to 0 either way.
- CAPTURE: exactly one cycle, with scan_en=0, chain_ce=1 and in_ready=0; then go to UNLOAD.
- UNLOAD:
  - in_ready=1 and chain_ce=in_valid; chain_si=0.
  - On each accepted beat, compare chain_so with in_data unless in_mask=1.
  - A mismatch sets fail, increments err_count (saturating at all-ones) and records the counter value in first_fail_idx if fail was previously 0.
  - After beat CHAIN_LEN-1, go to DONE.
- DONE: one cycle with done=1, busy=0 and scan_mode=0; then go to IDLE.
- Ordering: the first bit loaded lands at the SO end of the chain. UNLOAD beat k therefore observes the FF k positions from the SO end.
- Stalls: when in_valid=0, chain_ce=0 and the chain holds its contents. Stalls of any length are legal.

## Timing
- in_ready, chain_ce and chain_si are combinational from state and in_valid/in_data. All other outputs are registered.
- Reset values: state IDLE and every output 0 (chain_si=0, chain_ce=0, scan_en=0, scan_mode=0, err_count=0). The first_fail_idx register is also reset to 0.
- Latency: from start to done is LOAD beats + optional 1 capture cycle + UNLOAD beats + 1. With no stalls and capture on, this is 2·CHAIN_LEN+2 cycles.
- chain_so is sampled in the same cycle the beat is accepted, before the shift edge.
- start arriving in the DONE cycle is ignored. start is only accepted in IDLE.
- Reset asserted mid-pass: return to IDLE immediately; chain contents are undefined. No done pulse is produced.
- CHAIN_LEN=1: LOAD and UNLOAD each take exactly one beat; first_fail_idx is 0 on any failure.

## Structure
- Package scan_ctrl_pkg holds the state enum `scan_state_t` and a function for CNT_W.
- One sub-module, scan_beat_counter: a loadable CNT_W counter with a `last` flag at CHAIN_LEN-1. It is shared by LOAD and UNLOAD.

## Test plan
The bench models the chain as an 8-bit shift register with enable E; a capture edge loads ~Q (bitwise inverted).
- CHAIN_LEN=8, capture_en=0, pattern 8'hA5, expected 8'hA5, no stalls -> done at cycle 18; fail=0 and err_count=0.
- CHAIN_LEN=8, capture_en=1, pattern 8'hA5, expected 8'h5A -> done at cycle 19 (2·CHAIN_LEN+2=18 cycles after the start cycle); fail=0.
- Flush test with expected bits 2 and 5 flipped -> fail=1, err_count=2, first_fail_idx=2.
- Same mismatches as above, with in_mask=1 on beat 2 -> err_count=1, first_fail_idx=5.
- Random in_valid gaps of 0–5 cycles -> chain_ce tracks in_valid exactly; the result matches the no-stall run.
- global_resetn pulsed during UNLOAD beat 3 -> all outputs 0 asynchronously, no done pulse; a new start then runs a clean pass to completion.
